fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - Instruction fetch stage directly upstream of control_module: owns the program counter and reads a synchronous instruction ROM.
// - Presents instructions to the decoder over a valid/ready handshake.
// - Executes redirects (JMP, JZ, CALL, RET) requested by the decoder, using an internal return-address stack.
// PARAMETERS
// - PC_WIDTH     8   program counter / ROM address width
// - INSTR_WIDTH  32  instruction word width
// - STACK_DEPTH  8   return-stack entries (power of 2, >=2)
// PORTS
// - clk              in   1            single clock; all state updates on rising edge
// - rst              in   1            synchronous, active-high reset
// - rom_rd           out  1            ROM read strobe
// - rom_addr         out  PC_WIDTH     ROM read address
// - rom_data         in   INSTR_WIDTH  ROM read data, valid in the cycle after rom_rd
// - instr            out  INSTR_WIDTH  instruction to decoder
// - instr_addr       out  PC_WIDTH     address of instr
// - instr_valid      out  1            instr/instr_addr valid
// - instr_ready      in   1            decoder accepts (transfer = valid & ready)
// - redirect         in   1            decoder requests control transfer for the transferring instr
// - redirect_kind    in   2            00 JMP, 01 JZ, 10 CALL, 11 RET
// - redirect_target  in   PC_WIDTH     jump/call target
// - zero_flag        in   1            ALU zero flag, sampled for JZ
// - stack_overflow   out  1            sticky: CALL with stack full
// - stack_underflow  out  1            sticky: RET with stack empty
// BEHAVIOUR
// - Reset: pc=0, sp=0, rom_rd=0, rom_addr=0, instr=0, instr_addr=0, instr_valid=0; flags=0; skid and in-flight state cleared.
//   - rst asserted mid-operation: all of the above hold on the next edge; any in-flight rom_data is discarded.
// - Buffering: 2-entry elastic buffer (output reg + skid reg); no instruction is lost or duplicated under backpressure.
// - rom_rd issue rule: (occupancy after this cycle's dequeue) + (reads in flight) < 2.
//   - Each read: rom_addr = pc; pc increments by 1 (mod 2^PC_WIDTH; 0xFF wraps to 0x00 at default).
// - Latency: rom_rd in cycle T -> rom_data in T+1 -> instr_valid at earliest in T+2.
//   - First rom_rd occurs in the first cycle after rst deasserts (rom_addr=0).
// - Redirect is honoured only when redirect & instr_valid & instr_ready. Let A = instr_addr of that transfer.
//   - JMP: pc <= target.
//   - JZ: pc <= zero_flag ? target : A+1.
//   - CALL: push A+1, pc <= target. If stack full: push dropped, stack_overflow <= 1, jump still taken.
//   - RET: pc <= pop. If stack empty: stack_underflow <= 1, pc <= A+1.
//   - Flush on redirect: skid entry and any in-flight read are discarded; instr_valid=0 the following cycle.
//   - First rom_rd at the new pc occurs in cycle T+1; new instr_valid at T+3 (2 bubble cycles).
// - redirect without a transfer: ignored; no state change.
// - Stack: sp in 0..STACK_DEPTH; push and pop never occur in the same cycle (one redirect per transfer).
// - Overflow/underflow flags stay sticky until rst.
// CONFIGURATION
// - FETCH_CALL_STACK_EN defined: return stack and flags as above.
// - FETCH_CALL_STACK_EN undefined: no stack storage.
//   - CALL behaves as JMP; RET behaves as no redirect (pc continues sequentially).
//   - stack_overflow and stack_underflow tied to 0.
// TESTING
// - Sequential fetch: reset, ROM[i]=i+0x100, instr_ready=1 -> instr_valid first 2 cycles after first rom_rd; instr_addr 0,1,2,...; instr=0x100,0x101,...
// - Backpressure: instr_ready=0 for 5 cycles mid-stream -> rom_rd drops; at most 2 unaccepted/in-flight; on release, sequence resumes with no gap or duplicate.
// - JZ at addr 5, target 0x20: zero_flag=1 -> next instr_addr=0x20 three cycles later; zero_flag=0 -> next instr_addr=6.
// - CALL at 3 to 0x40, RET at 0x41 -> instr_addr 0x40, 0x41, then 4.
// - 9 nested CALLs -> stack_overflow=1 after 9th; then 9 RETs -> 8 correct returns; 9th sets stack_underflow=1 and falls through to A+1.
// - PC wrap and reset: fetch 0xFE, 0xFF, 0x00 continuously; assert rst during backpressure -> next cycle all outputs at reset values; fetch restarts at 0.
// - Build without FETCH_CALL_STACK_EN: CALL jumps to target; RET continues at A+1; both flags stay 0.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage sitting directly in front of the decoder
//   (control_module). Owns the program counter, reads a synchronous
//   instruction ROM (one cycle read latency) and hands instructions to the
//   decoder over a valid/ready handshake through a 2-entry elastic buffer
//   (output register + skid register). Executes JMP / JZ / CALL / RET
//   redirects requested by the decoder for the instruction being transferred.
//
// Build option
//   FETCH_CALL_STACK_EN : when defined, CALL/RET use an internal return-address
//                         stack with sticky overflow/underflow flags. When
//                         undefined there is no stack storage: CALL acts as
//                         JMP, RET is ignored, and both flags read 0.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   rom_rd, rom_addr  ROM read strobe / address (rom_addr always shows pc)
//   rom_data          ROM read data, valid the cycle after rom_rd
//   instr, instr_addr instruction and its address towards the decoder
//   instr_valid       instr/instr_addr valid
//   instr_ready       decoder accepts (transfer = instr_valid & instr_ready)
//   redirect          control transfer request for the transferring instr
//   redirect_kind     00 JMP, 01 JZ, 10 CALL, 11 RET
//   redirect_target   jump/call target
//   zero_flag         ALU zero flag, sampled for JZ
//   stack_overflow    sticky: CALL while stack full
//   stack_underflow   sticky: RET while stack empty
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int STACK_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rom_rd,
  output logic [PC_WIDTH-1:0]    rom_addr,
  input  logic [INSTR_WIDTH-1:0] rom_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_addr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect,
  input  logic [1:0]             redirect_kind,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  input  logic                   zero_flag,
  output logic                   stack_overflow,
  output logic                   stack_underflow
);

  localparam logic [1:0] KIND_JMP  = 2'b00;
  localparam logic [1:0] KIND_JZ   = 2'b01;
  localparam logic [1:0] KIND_CALL = 2'b10;
  localparam logic [1:0] KIND_RET  = 2'b11;

  // Fetch pipeline state
  logic [PC_WIDTH-1:0]    pc_reg, pc_next;
  logic                   pending_reg, pending_next;        // read issued last cycle
  logic [PC_WIDTH-1:0]    pending_addr_reg, pending_addr_next;
  logic [INSTR_WIDTH-1:0] out_instr_reg, out_instr_next;
  logic [PC_WIDTH-1:0]    out_addr_reg, out_addr_next;
  logic                   out_valid_reg, out_valid_next;
  logic [INSTR_WIDTH-1:0] skid_instr_reg, skid_instr_next;
  logic [PC_WIDTH-1:0]    skid_addr_reg, skid_addr_next;
  logic                   skid_valid_reg, skid_valid_next;

  logic                   xfer;
  logic                   take;       // honoured redirect: flush and load pc
  logic [PC_WIDTH-1:0]    target_pc;
  logic [PC_WIDTH-1:0]    seq_addr;   // A+1 of the transferring instruction
  logic [2:0]             occ_after;
  logic                   issue;

  assign xfer     = out_valid_reg & instr_ready;
  assign seq_addr = out_addr_reg + PC_WIDTH'(1);

`ifdef FETCH_CALL_STACK_EN
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]     sp_reg, sp_next;
  logic                ovf_reg, ovf_next;
  logic                unf_reg, unf_next;
  logic                push_en, pop_en;
  logic                stack_full, stack_empty;
  logic [SP_W-2:0]     push_idx, top_idx;
  logic [PC_WIDTH-1:0] stack_top;

  assign stack_full  = (sp_reg == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_reg == '0);
  assign push_idx    = sp_reg[SP_W-2:0];
  // sp == STACK_DEPTH truncates to 0, so minus one still lands on the top entry
  assign top_idx     = sp_reg[SP_W-2:0] - (SP_W-1)'(1);
  // Read combinationally so a RET can redirect in the cycle it transfers
  assign stack_top   = stack_mem[top_idx];

  assign stack_overflow  = ovf_reg;
  assign stack_underflow = unf_reg;
`else
  // Keeps STACK_DEPTH referenced in builds without the stack
  logic [31:0] unused_depth;
  assign unused_depth    = 32'(STACK_DEPTH);
  assign stack_overflow  = 1'b0;
  assign stack_underflow = 1'b0;
`endif

  // Redirect decode; only meaningful when the tagged instruction transfers
  always_comb begin
    take      = 1'b0;
    target_pc = seq_addr;
`ifdef FETCH_CALL_STACK_EN
    push_en   = 1'b0;
    pop_en    = 1'b0;
`endif
    if (redirect && xfer) begin
      case (redirect_kind)
        KIND_JMP: begin
          take      = 1'b1;
          target_pc = redirect_target;
        end
        KIND_JZ: begin
          take      = 1'b1;
          target_pc = zero_flag ? redirect_target : seq_addr;
        end
        KIND_CALL: begin
          take      = 1'b1;
          target_pc = redirect_target;
`ifdef FETCH_CALL_STACK_EN
          push_en   = 1'b1;
`endif
        end
        KIND_RET: begin
`ifdef FETCH_CALL_STACK_EN
          take      = 1'b1;
          pop_en    = 1'b1;
          target_pc = stack_empty ? seq_addr : stack_top;
`endif
        end
        default: ;
      endcase
    end
  end

  // Issue a read only if everything already owed to the buffer, plus this
  // read, still fits in the two entries after this cycle's dequeue.
  assign occ_after = 3'(out_valid_reg) + 3'(skid_valid_reg) + 3'(pending_reg) - 3'(xfer);
  assign issue     = (occ_after < 3'd2);
  assign rom_rd    = !rst && !take && issue;
  assign rom_addr  = pc_reg;

  // Elastic buffer / pc next-state
  always_comb begin
    pc_next           = rom_rd ? pc_reg + PC_WIDTH'(1) : pc_reg;
    pending_next      = rom_rd;
    pending_addr_next = pc_reg;
    out_instr_next    = out_instr_reg;
    out_addr_next     = out_addr_reg;
    out_valid_next    = out_valid_reg;
    skid_instr_next   = skid_instr_reg;
    skid_addr_next    = skid_addr_reg;
    skid_valid_next   = skid_valid_reg;

    if (take) begin
      // Drop everything fetched down the old path, including the arriving word
      pc_next         = target_pc;
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!out_valid_reg || xfer) begin
      if (skid_valid_reg) begin
        out_instr_next  = skid_instr_reg;
        out_addr_next   = skid_addr_reg;
        out_valid_next  = 1'b1;
        skid_valid_next = pending_reg;
        if (pending_reg) begin
          skid_instr_next = rom_data;
          skid_addr_next  = pending_addr_reg;
        end
      end else begin
        out_valid_next = pending_reg;
        if (pending_reg) begin
          out_instr_next = rom_data;
          out_addr_next  = pending_addr_reg;
        end
      end
    end else if (pending_reg) begin
      // Output stalled: the arriving word parks in the skid register
      skid_instr_next = rom_data;
      skid_addr_next  = pending_addr_reg;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg           <= '0;
      pending_reg      <= 1'b0;
      pending_addr_reg <= '0;
      out_instr_reg    <= '0;
      out_addr_reg     <= '0;
      out_valid_reg    <= 1'b0;
      skid_instr_reg   <= '0;
      skid_addr_reg    <= '0;
      skid_valid_reg   <= 1'b0;
    end else begin
      pc_reg           <= pc_next;
      pending_reg      <= pending_next;
      pending_addr_reg <= pending_addr_next;
      out_instr_reg    <= out_instr_next;
      out_addr_reg     <= out_addr_next;
      out_valid_reg    <= out_valid_next;
      skid_instr_reg   <= skid_instr_next;
      skid_addr_reg    <= skid_addr_next;
      skid_valid_reg   <= skid_valid_next;
    end
  end

  assign instr       = out_instr_reg;
  assign instr_addr  = out_addr_reg;
  assign instr_valid = out_valid_reg;

`ifdef FETCH_CALL_STACK_EN
  // Stack pointer and sticky flags; a full CALL still jumps, an empty RET
  // falls through to A+1 (handled in the redirect decode).
  always_comb begin
    sp_next  = sp_reg;
    ovf_next = ovf_reg;
    unf_next = unf_reg;
    if (push_en) begin
      if (stack_full) ovf_next = 1'b1;
      else            sp_next  = sp_reg + SP_W'(1);
    end
    if (pop_en) begin
      if (stack_empty) unf_next = 1'b1;
      else             sp_next  = sp_reg - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_reg  <= '0;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      sp_reg  <= sp_next;
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_en && !stack_full) begin
      stack_mem[push_idx] <= seq_addr;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A behavioural ROM (ROM[i] = 0x100 + i)
//   answers reads one cycle after rom_rd; the bench plays the decoder.
//   Expectations follow the FETCH_CALL_STACK_EN setting of the build.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        rom_rd;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] instr;
  logic [7:0]  instr_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [1:0]  redirect_kind;
  logic [7:0]  redirect_target;
  logic        zero_flag;
  logic        stack_overflow;
  logic        stack_underflow;

  int total = 0;
  int bad   = 0;

  logic [31:0] rom_mem [256];
  logic [7:0]  cur;
  logic [7:0]  tgt;
  logic [7:0]  nxt;

`ifdef FETCH_CALL_STACK_EN
  localparam logic STK_EN = 1'b1;
  logic [7:0] stk_m [8];
  int         sp_m;
`else
  localparam logic STK_EN = 1'b0;
`endif

  fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(32), .STACK_DEPTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_rd          (rom_rd),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .instr           (instr),
    .instr_addr      (instr_addr),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_kind   (redirect_kind),
    .redirect_target (redirect_target),
    .zero_flag       (zero_flag),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_rd) rom_data <= rom_mem[rom_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Current cycle must present address a; then let it transfer
  task automatic see(input logic [7:0] a);
    chk("xfer", 64'({instr_valid, instr_addr, instr}), 64'({1'b1, a, 32'h100 + {24'h0, a}}));
    step();
  endtask

  // Redirect on the transfer of address a; check flush, refetch and the
  // two bubble cycles; ends in the cycle that presents nxt (not transferred)
  task automatic redir(input logic [7:0] a, input logic [1:0] k, input logic [7:0] t,
                       input logic z, input logic [7:0] n);
    redirect = 1'b1; redirect_kind = k; redirect_target = t; zero_flag = z;
    #1;
    chk("redir_src", 64'({instr_valid, instr_addr, instr}), 64'({1'b1, a, 32'h100 + {24'h0, a}}));
    chk("redir_rd_gated", 64'(rom_rd), 64'(1'b0));
    step();
    redirect = 1'b0;
    #1;
    chk("bubble1_valid", 64'(instr_valid), 64'(1'b0));
    chk("refetch_rd", 64'(rom_rd), 64'(1'b1));
    chk("refetch_addr", 64'(rom_addr), 64'(n));
    step();
    chk("bubble2_valid", 64'(instr_valid), 64'(1'b0));
    step();
    chk("redir_dst", 64'({instr_valid, instr_addr, instr}), 64'({1'b1, n, 32'h100 + {24'h0, n}}));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 32'h100 + 32'(i);
    rom_data        = '0;
    rst             = 1'b1;
    instr_ready     = 1'b1;
    redirect        = 1'b0;
    redirect_kind   = 2'b00;
    redirect_target = 8'h00;
    zero_flag       = 1'b0;

    // Reset state
    step();
    chk("rst_rom_rd", 64'(rom_rd), 64'(1'b0));
    chk("rst_rom_addr", 64'(rom_addr), 64'(8'h00));
    chk("rst_valid", 64'(instr_valid), 64'(1'b0));
    chk("rst_instr", 64'(instr), 64'(32'h0));
    chk("rst_instr_addr", 64'(instr_addr), 64'(8'h00));
    chk("rst_flags", 64'({stack_overflow, stack_underflow}), 64'(2'b00));
    step();
    rst = 1'b0;
    #1;

    // Sequential fetch: first read right after reset, valid two cycles later
    chk("first_rd", 64'(rom_rd), 64'(1'b1));
    chk("first_addr", 64'(rom_addr), 64'(8'h00));
    step();
    chk("lat_valid", 64'(instr_valid), 64'(1'b0));
    chk("second_addr", 64'(rom_addr), 64'(8'h01));
    step();
    see(8'h00); see(8'h01); see(8'h02);

    // Backpressure for 5 cycles while 3 is presented
    instr_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_no_rd", 64'(rom_rd), 64'(1'b0));
      chk("bp_hold", 64'({instr_valid, instr_addr}), 64'({1'b1, 8'h03}));
      step();
    end
    instr_ready = 1'b1;
    #1;
    chk("bp_release_rd", 64'(rom_rd), 64'(1'b1));
    chk("bp_release_addr", 64'(rom_addr), 64'(8'h05));
    see(8'h03); see(8'h04);

    // JZ taken, JMP back, JZ not taken, JMP to 3
    redir(8'h05, 2'b01, 8'h20, 1'b1, 8'h20);
    see(8'h20);
    redir(8'h21, 2'b00, 8'h05, 1'b0, 8'h05);
    redir(8'h05, 2'b01, 8'h20, 1'b0, 8'h06);
    redir(8'h06, 2'b00, 8'h03, 1'b0, 8'h03);

    // CALL at 3 to 0x40, RET at 0x41
    redir(8'h03, 2'b10, 8'h40, 1'b0, 8'h40);
    see(8'h40);
`ifdef FETCH_CALL_STACK_EN
    redir(8'h41, 2'b11, 8'h00, 1'b0, 8'h04);
    cur  = 8'h04;
    sp_m = 0;
`else
    redirect = 1'b1; redirect_kind = 2'b11;
    #1;
    chk("ret_ignored_rd", 64'(rom_rd), 64'(1'b1));
    see(8'h41);
    redirect = 1'b0;
    see(8'h42);
    cur = 8'h43;
`endif

    // Nine nested CALLs
    for (int i = 0; i < 9; i++) begin
      tgt = 8'h80 + 8'(8 * i);
      if (i == 8) chk("ovf_before", 64'(stack_overflow), 64'(1'b0));
`ifdef FETCH_CALL_STACK_EN
      if (sp_m < 8) begin
        stk_m[sp_m] = cur + 8'd1;
        sp_m++;
      end
`endif
      redir(cur, 2'b10, tgt, 1'b0, tgt);
      see(tgt);
      cur = tgt + 8'd1;
    end
    chk("ovf_after", 64'(stack_overflow), 64'(STK_EN));

    // Nine RETs
    for (int j = 0; j < 9; j++) begin
      if (j == 8) chk("unf_before", 64'(stack_underflow), 64'(1'b0));
`ifdef FETCH_CALL_STACK_EN
      if (sp_m > 0) begin
        sp_m--;
        nxt = stk_m[sp_m];
      end else begin
        nxt = cur + 8'd1;
      end
      redir(cur, 2'b11, 8'h00, 1'b0, nxt);
      cur = nxt;
`else
      redirect = 1'b1; redirect_kind = 2'b11;
      #1;
      see(cur);
      redirect = 1'b0;
      cur = cur + 8'd1;
`endif
    end
    chk("unf_after", 64'(stack_underflow), 64'(STK_EN));
    chk("ovf_sticky", 64'(stack_overflow), 64'(STK_EN));

    // PC wrap
    redir(cur, 2'b00, 8'hFE, 1'b0, 8'hFE);
    see(8'hFE); see(8'hFF); see(8'h00);

    // Reset while backpressured
    instr_ready = 1'b0;
    #1;
    step(); step();
    rst = 1'b1;
    step();
    chk("mid_rst_rom_rd", 64'(rom_rd), 64'(1'b0));
    chk("mid_rst_rom_addr", 64'(rom_addr), 64'(8'h00));
    chk("mid_rst_valid", 64'(instr_valid), 64'(1'b0));
    chk("mid_rst_instr", 64'(instr), 64'(32'h0));
    chk("mid_rst_instr_addr", 64'(instr_addr), 64'(8'h00));
    chk("mid_rst_flags", 64'({stack_overflow, stack_underflow}), 64'(2'b00));
    rst = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk("restart_rd", 64'(rom_rd), 64'(1'b1));
    chk("restart_addr", 64'(rom_addr), 64'(8'h00));
    step();
    chk("restart_lat", 64'(instr_valid), 64'(1'b0));
    step();
    see(8'h00); see(8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
